alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Bit-serial sequencer for the 1-bit ALU slice. It accepts register-to-register commands over a valid/ready handshake and reads two operands from an internal register file. It drives the slice LSB-first for WIDTH cycles, chaining carry through a flop, then writes the result back and reports flags. It sits between the command source (host or test bench) and a single external bALU-style slice.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- NREGS, 4, register file depth; AW = $clog2(NREGS)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  opcode
- cmd_rd, cmd_rs0, cmd_rs1  in  AW  destination and source register indices
- reg_we  in  1  host register write strobe
- reg_waddr  in  AW  host write index
- reg_wdata  in  WIDTH  host write data
- reg_raddr  in  AW  host read index
- reg_rdata  out  WIDTH  combinational read of R[reg_raddr]
- alu_op  out  3  opcode to slice
- alu_a, alu_b, alu_cin  out  1  slice operand bits and carry-in
- alu_y, alu_cout  in  1  slice result bit and carry-out (combinational from the slice)
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: illegal opcode
- res  out  WIDTH  result, valid with done
- flag_c, flag_z  out  1  carry and zero, valid with done

## Operation
- Opcodes: MOV 000 (y=a), NOT 001 (y=~a), ADD 010, NOR 100, NAND 101, SUB 110. 011 and 111 are illegal.
- States: IDLE, RUN, WB, ERR.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op and rd; load a_sh=R[rs0], b_sh=R[rs1], cnt=0.
  - Set carry flop = 1 if op==SUB, else 0.
  - Legal op goes to RUN; illegal op goes to ERR.
- RUN:
  - Drive alu_op=op, alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry.
  - Each edge: res_sh <= {alu_y, res_sh[WIDTH-1:1]}; carry <= alu_cout; shift a_sh and b_sh right; cnt++.
  - After WIDTH RUN cycles, go to WB.
- WB (one cycle):
  - done=1, err=0; R[rd] <= res_sh; res=res_sh.
  - flag_z = (res_sh==0).
  - flag_c = carry for ADD/SUB, 0 otherwise. For SUB, flag_c=1 means no borrow.
  - Next state IDLE.
- ERR (one cycle): done=1, err=1, res=0, flags 0, no register write; next state IDLE.
- MOV and NOT ignore rs1; b_sh still shifts.
- Operands snapshot at the accept edge: a reg_we landing on the same edge is not seen by that command.
- Host writes:
  - Honoured only in IDLE; reg_we in RUN/WB/ERR is dropped.
  - In IDLE, reg_we and command accept can coincide.
- cmd_valid while not IDLE is not accepted; the source holds it until cmd_ready.
- Arithmetic is modulo 2^WIDTH; no overflow flag.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..WIDTH. WB in cycle WIDTH+1 (done high, R[rd] updated at its end). cmd_ready high again in cycle WIDTH+2.
- Throughput: one command per WIDTH+2 cycles. Illegal op: done+err in cycle 1, cmd_ready in cycle 2.
- reg_rdata is combinational; it shows the written-back value from cycle WIDTH+2.
- Reset values: state IDLE; cmd_ready=1 in the first cycle after reset; done=0, err=0, res=0, flag_c=0, flag_z=0; alu_op/alu_a/alu_b/alu_cin=0; cnt=0, carry=0.
- Outside RUN, all alu_* outputs are 0.
- The register file is not reset; contents persist across rst.
- rst mid-operation aborts with no write-back, no done, and returns to IDLE on the next edge.

## Test plan
Bench uses a behavioural slice matching the opcode table, WIDTH=8.
- ADD: R1=0x5A, R2=0x3C, ADD rd=3 -> done exactly in cycle 9 after accept, res=0x96, flag_c=0, flag_z=0; reg_rdata(3)=0x96 in cycle 10; cmd_ready low in cycles 1-9.
- Arithmetic edges:
  - ADD 0xFF+0x01 -> res=0x00, flag_c=1, flag_z=1.
  - SUB R1-R1 (0x5A) -> 0x00, flag_c=1, flag_z=1.
  - SUB 0x3C-0x5A -> 0xE2, flag_c=0.
- Logic ops with R1=0x5A, R2=0x3C:
  - NAND -> 0xE7; NOR -> 0x81; NOT R1 -> 0xA5; MOV R1 -> 0x5A.
  - flag_c=0 for all four.
- Illegal op 011 -> done=1 and err=1 in cycle 1, res=0, R[rd] unchanged; a following legal command is accepted in cycle 2.
- Hazards:
  - reg_we R1=0x01 on the accept edge of ADD R1+R2 -> result uses old R1.
  - reg_we during RUN -> dropped.
  - cmd_valid held high through busy -> exactly one accept per WIDTH+2 cycles.
- rst asserted in cycle 4 of ADD rd=3 (R3 preloaded 0x11) -> no done; cmd_ready=1 the cycle after rst drops; R3 still 0x11.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: snapshots two operands from a small
// register file, streams them LSB-first through the slice, then writes back and reports flags.
module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs0,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic             reg_we,
    input  logic [AW-1:0]    reg_waddr,
    input  logic [WIDTH-1:0] reg_wdata,
    input  logic [AW-1:0]    reg_raddr,
    output logic [WIDTH-1:0] reg_rdata,
    output logic [2:0]       alu_op,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    input  logic             alu_y,
    input  logic             alu_cout,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] res,
    output logic             flag_c,
    output logic             flag_z
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10,
        ERR  = 2'b11
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b011, 3'b111: op_legal = 1'b0;
            default:        op_legal = 1'b1;
        endcase
    endfunction

    function automatic logic op_arith(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: op_arith = 1'b1;
            default:        op_arith = 1'b0;
        endcase
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       op_r;
    logic [AW-1:0]    rd_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [WIDTH-1:0] res_nx_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             done_r;
    logic             err_r;
    logic [WIDTH-1:0] res_r;
    logic             flag_c_r;
    logic             flag_z_r;
    logic             run_s;
    logic [WIDTH-1:0] regs_r [NREGS];

    assign run_s     = (state_r == RUN);
    assign res_nx_s  = {alu_y, res_sh_r[WIDTH-1:1]};
    assign cmd_ready = (state_r == IDLE);
    assign reg_rdata = regs_r[reg_raddr];

    // Slice drive is gated so it idles at zero outside RUN
    assign alu_op  = run_s ? op_r : 3'b000;
    assign alu_a   = run_s & a_sh_r[0];
    assign alu_b   = run_s & b_sh_r[0];
    assign alu_cin = run_s & carry_r;

    assign done   = done_r;
    assign err    = err_r;
    assign res    = res_r;
    assign flag_c = flag_c_r;
    assign flag_z = flag_z_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx_s = op_legal(cmd_op) ? RUN : ERR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = WB;
                end else begin
                    state_nx_s = RUN;
                end
            end
            WB:      state_nx_s = IDLE;
            ERR:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Operand shifters, carry chain and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 3'b000;
            rd_r     <= {AW{1'b0}};
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            carry_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            res_r    <= {WIDTH{1'b0}};
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= cmd_op;
                        rd_r    <= cmd_rd;
                        a_sh_r  <= regs_r[cmd_rs0];
                        b_sh_r  <= regs_r[cmd_rs1];
                        cnt_r   <= {CW{1'b0}};
                        carry_r <= (cmd_op == OP_SUB);
                        if (!op_legal(cmd_op)) begin
                            done_r   <= 1'b1;
                            err_r    <= 1'b1;
                            res_r    <= {WIDTH{1'b0}};
                            flag_c_r <= 1'b0;
                            flag_z_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    res_sh_r <= res_nx_s;
                    carry_r  <= alu_cout;
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    // Publish on the final edge so done and res are registered during WB
                    if (cnt_r == CNT_LAST) begin
                        done_r   <= 1'b1;
                        res_r    <= res_nx_s;
                        flag_z_r <= (res_nx_s == {WIDTH{1'b0}});
                        flag_c_r <= op_arith(op_r) & alu_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file: host writes only while idle, write-back at the end of WB; never reset
    always_ff @(posedge clk) begin
        if (!rst && (state_r == IDLE) && reg_we) begin
            regs_r[reg_waddr] <= reg_wdata;
        end else if (!rst && (state_r == WB)) begin
            regs_r[rd_r] <= res_r;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural 1-bit ALU slice.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [1:0] cmd_rd = 2'd0, cmd_rs0 = 2'd0, cmd_rs1 = 2'd0;
    logic       reg_we = 1'b0;
    logic [1:0] reg_waddr = 2'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic [1:0] reg_raddr = 2'd0;
    logic [7:0] reg_rdata;
    logic [2:0] alu_op;
    logic       alu_a, alu_b, alu_cin;
    logic       alu_y, alu_cout;
    logic       done, err, flag_c, flag_z;
    logic [7:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs0(cmd_rs0), .cmd_rs1(cmd_rs1),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .done(done), .err(err), .res(res), .flag_c(flag_c), .flag_z(flag_z)
    );

    // Behavioural slice
    always_comb begin
        alu_y    = 1'b0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b000:  alu_y = alu_a;
            3'b001:  alu_y = ~alu_a;
            3'b010:  {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {1'b0, alu_cin};
            3'b100:  alu_y = ~(alu_a | alu_b);
            3'b101:  alu_y = ~(alu_a & alu_b);
            3'b110:  {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + {1'b0, alu_cin};
            default: alu_y = 1'b0;
        endcase
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
        step();
        reg_we = 1'b0;
    endtask

    // Issue one command from IDLE and wait (bounded) for done; returns in the following cycle
    task automatic exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] s0,
                        input logic [1:0] s1, input logic poke, output logic got,
                        output int lat, output logic [7:0] r, output logic c,
                        output logic z, output logic e);
        cmd_op = op; cmd_rd = rd; cmd_rs0 = s0; cmd_rs1 = s1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        reg_we = poke;
        got = 1'b0; lat = 1; r = 8'h00; c = 1'b0; z = 1'b0; e = 1'b0;
        while (!got && lat < 20) begin
            if (done === 1'b1) begin
                got = 1'b1; r = res; c = flag_c; z = flag_z; e = err;
                reg_we = 1'b0;
            end else begin
                step();
                reg_we = 1'b0;
                lat++;
            end
        end
        if (got) step();
    endtask

    task automatic test_reset();
        step(); step();
        rst = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", cmd_ready); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b exp 00", done, err); end
        n_checks++; if (res !== 8'h00 || flag_c !== 1'b0 || flag_z !== 1'b0) begin n_fail++; $display("FAIL reset_res_flags: got %h %b%b exp 00 00", res, flag_c, flag_z); end
        n_checks++; if ({alu_op, alu_a, alu_b, alu_cin} !== 6'b000000) begin n_fail++; $display("FAIL reset_alu: got %b exp 000000", {alu_op, alu_a, alu_b, alu_cin}); end
    endtask

    task automatic test_add();
        host_write(2'd1, 8'h5A);
        host_write(2'd2, 8'h3C);
        reg_raddr = 2'd3;
        cmd_op = 3'b010; cmd_rd = 2'd3; cmd_rs0 = 2'd1; cmd_rs1 = 2'd2; cmd_valid = 1'b1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready0: got %b exp 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy c%0d: ready %b exp 0", c, cmd_ready); end
            n_checks++; if (done !== ((c == 9) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL add_done c%0d: got %b", c, done); end
            if (c == 1) begin
                n_checks++; if (alu_op !== 3'b010 || alu_cin !== 1'b0) begin n_fail++; $display("FAIL add_alu_drive: op %b cin %b exp 010 0", alu_op, alu_cin); end
            end
            if (c == 9) begin
                n_checks++; if (res !== 8'h96) begin n_fail++; $display("FAIL add_res: got %h exp 96", res); end
                n_checks++; if (flag_c !== 1'b0 || flag_z !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL add_flags: c%b z%b e%b exp 000", flag_c, flag_z, err); end
                n_checks++; if (alu_op !== 3'b000) begin n_fail++; $display("FAIL add_alu_wb: got %b exp 000", alu_op); end
            end else begin
                step();
            end
        end
        step();
        n_checks++; if (reg_rdata !== 8'h96) begin n_fail++; $display("FAIL add_wb_r3: got %h exp 96", reg_rdata); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready10: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_arith_edges();
        logic got, c, z, e; int lat; logic [7:0] r;
        host_write(2'd1, 8'hFF);
        host_write(2'd2, 8'h01);
        exec(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || lat != 9) begin n_fail++; $display("FAIL add_ff_lat: got %b lat %0d exp 1 9", got, lat); end
        n_checks++; if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin n_fail++; $display("FAIL add_ff: res %h c%b z%b exp 00 c1 z1", r, c, z); end
        host_write(2'd1, 8'h5A);
        host_write(2'd2, 8'h3C);
        exec(3'b110, 2'd0, 2'd1, 2'd1, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || r !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin n_fail++; $display("FAIL sub_self: res %h c%b z%b exp 00 c1 z1", r, c, z); end
        exec(3'b110, 2'd0, 2'd2, 2'd1, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || r !== 8'hE2 || c !== 1'b0 || z !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: res %h c%b z%b exp E2 c0 z0", r, c, z); end
    endtask

    task automatic test_logic();
        logic got, c, z, e; int lat; logic [7:0] r;
        logic [2:0] ops [4];
        logic [7:0] exp_r [4];
        ops   = '{3'b101, 3'b100, 3'b001, 3'b000};
        exp_r = '{8'hE7, 8'h81, 8'hA5, 8'h5A};
        reg_raddr = 2'd0;
        for (int i = 0; i < 4; i++) begin
            exec(ops[i], 2'd0, 2'd1, 2'd2, 1'b0, got, lat, r, c, z, e);
            n_checks++; if (got !== 1'b1 || r !== exp_r[i]) begin n_fail++; $display("FAIL logic_res op%b: got %h exp %h", ops[i], r, exp_r[i]); end
            n_checks++; if (c !== 1'b0 || z !== 1'b0) begin n_fail++; $display("FAIL logic_flags op%b: c%b z%b exp 00", ops[i], c, z); end
            n_checks++; if (reg_rdata !== exp_r[i]) begin n_fail++; $display("FAIL logic_wb op%b: R0 %h exp %h", ops[i], reg_rdata, exp_r[i]); end
        end
    endtask

    task automatic test_illegal();
        logic got, c, z, e; int lat; logic [7:0] r;
        host_write(2'd3, 8'h77);
        reg_raddr = 2'd3;
        exec(3'b011, 2'd3, 2'd1, 2'd2, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || lat != 1 || e !== 1'b1) begin n_fail++; $display("FAIL ill_done: got %b lat %0d err %b exp 1 1 1", got, lat, e); end
        n_checks++; if (r !== 8'h00 || c !== 1'b0 || z !== 1'b0) begin n_fail++; $display("FAIL ill_res: res %h c%b z%b exp 00 00", r, c, z); end
        n_checks++; if (reg_rdata !== 8'h77) begin n_fail++; $display("FAIL ill_r3: got %h exp 77", reg_rdata); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready2: got %b exp 1", cmd_ready); end
        exec(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || lat != 9 || r !== 8'h96 || e !== 1'b0) begin n_fail++; $display("FAIL ill_next: got %b lat %0d res %h err %b exp 1 9 96 0", got, lat, r, e); end
        exec(3'b111, 2'd3, 2'd1, 2'd2, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || lat != 1 || e !== 1'b1 || reg_rdata !== 8'h77) begin n_fail++; $display("FAIL ill_111: lat %0d err %b R3 %h exp 1 1 77", lat, e, reg_rdata); end
    endtask

    task automatic test_hazards();
        logic got, c, z, e; int lat; logic [7:0] r;
        host_write(2'd1, 8'h5A);
        host_write(2'd2, 8'h3C);
        reg_we = 1'b1; reg_waddr = 2'd1; reg_wdata = 8'h01;
        exec(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || r !== 8'h96) begin n_fail++; $display("FAIL haz_snapshot: res %h exp 96", r); end
        reg_raddr = 2'd1; #1;
        n_checks++; if (reg_rdata !== 8'h01) begin n_fail++; $display("FAIL haz_accept_write: R1 %h exp 01", reg_rdata); end
        reg_waddr = 2'd2; reg_wdata = 8'hAA;
        exec(3'b010, 2'd0, 2'd1, 2'd2, 1'b1, got, lat, r, c, z, e);
        n_checks++; if (got !== 1'b1 || r !== 8'h3D) begin n_fail++; $display("FAIL haz_run_res: res %h exp 3D", r); end
        reg_raddr = 2'd2; #1;
        n_checks++; if (reg_rdata !== 8'h3C) begin n_fail++; $display("FAIL haz_run_drop: R2 %h exp 3C", reg_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc [4];
        int n_acc = 0;
        int n_done = 0;
        cmd_op = 3'b010; cmd_rd = 2'd0; cmd_rs0 = 2'd1; cmd_rs1 = 2'd2; cmd_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (cmd_valid && cmd_ready) begin
                if (n_acc < 4) acc[n_acc] = i;
                n_acc++;
            end
            if (done === 1'b1) n_done++;
            step();
        end
        cmd_valid = 1'b0;
        n_checks++; if (n_acc != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d exp 3", n_acc); end
        n_checks++; if (n_acc >= 3 && (acc[0] != 0 || acc[1] != 10 || acc[2] != 20)) begin n_fail++; $display("FAIL b2b_spacing: got %0d %0d %0d exp 0 10 20", acc[0], acc[1], acc[2]); end
        n_checks++; if (n_done != 3) begin n_fail++; $display("FAIL b2b_dones: got %0d exp 3", n_done); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: ready %b exp 1", cmd_ready); end
    endtask

    task automatic test_rst_abort();
        int n_done = 0;
        host_write(2'd3, 8'h11);
        reg_raddr = 2'd3;
        cmd_op = 3'b010; cmd_rd = 2'd3; cmd_rs0 = 2'd1; cmd_rs1 = 2'd2; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", cmd_ready); end
        n_checks++; if (alu_op !== 3'b000 || done !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: alu_op %b done %b exp 000 0", alu_op, done); end
        repeat (12) begin
            if (done === 1'b1) n_done++;
            step();
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d exp 0", n_done); end
        n_checks++; if (reg_rdata !== 8'h11) begin n_fail++; $display("FAIL rst_r3: got %h exp 11", reg_rdata); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith_edges();
        test_logic();
        test_illegal();
        test_hazards();
        test_back_to_back();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
